mac_iter_acc: RTL and testbench
===============================

// Module: mac_iter_acc
// PURPOSE
//  Parametrised successor to the combinational-multiplier MAC. It multiplies
//  serially (shift-add, one bit per cycle), supports signed/unsigned mode, adds
//  guard bits with saturation, and dumps the result after K terms.
//  Valid/ready handshakes on input and output; sits between sample feeder and
//  dot-product consumer in the accelerator datapath.
// PARAMETERS
//  N       18  operand width (W, X)
//  G        4  accumulator guard bits; ACW = 2N+G
//  K        8  terms per dot product before result is presented (K>=1)
//  SIGNED   0  0: unsigned operands/accumulator; 1: two's-complement
// PORTS
//  clk        in   1     single clock, rising edge
//  Rst        in   1     reset, synchronous, active-high
//  in_valid   in   1     W/X pair valid
//  in_ready   out  1     block can accept a pair (high only in IDLE)
//  W          in   N     weight operand
//  X          in   N     data operand
//  out_valid  out  1     Out holds a completed K-term sum
//  out_ready  in   1     consumer accepts Out
//  Out        out  ACW   accumulated (saturated) result
//  Ovf        out  1     sticky: saturation occurred in current dot product
// BEHAVIOUR
//  - Reset (sync, any state, mid-operation included): state=IDLE, AC=0, term
//    count=0, bit count=0, in_ready=1 after edge, out_valid=0, Out=0, Ovf=0.
//  - FSM: IDLE -> MUL -> ACC -> (IDLE | DONE); DONE -> IDLE.
//  - IDLE: in_ready=1. in_valid&in_ready latches W,X; goes to MUL, bitcnt=0.
//    SIGNED=1: latch |W|,|X| and sign = W[N-1]^X[N-1].
//  - MUL: exactly N cycles; cycle i adds (W_mag<<i) to product reg if X_mag[i].
//    in_valid ignored (in_ready=0).
//  - ACC: 1 cycle. Product sign-applied, extended to ACW+1 bits, added to AC.
//    Result outside range (unsigned: 0..2^ACW-1; signed: -2^(ACW-1)..
//    2^(ACW-1)-1) clamps to nearest bound and sets Ovf. term++.
//    term==K -> DONE, else -> IDLE.
//  - Per-term latency: accept edge to in_ready re-high = N+2 cycles.
//  - DONE: out_valid=1, Out=AC (Out also shows AC in other states, qualified
//    only by out_valid). Held stable until out_valid&out_ready; on that edge
//    AC=0, term=0, Ovf=0, -> IDLE. No input accepted while in DONE.
//  - Saturated AC keeps accumulating from the clamped value (no wrap ever).
//  - K=1: every term goes ACC -> DONE.
// STRUCTURE
//  - Shared package mac_pkg: state encoding localparams (IDLE/MUL/ACC/DONE),
//    ACW width function, clog2-based counter widths for N and K, sat bounds.
//  - One sub-module: shift_add_mult (N-bit serial unsigned multiplier, start/
//    busy/done, 2N-bit product); sign fix, saturation, FSM in top.
// TESTING
//  1 N=4,G=2,K=2,U: (3,5) then (7,2) -> out_valid after 2*(N+2)=12 cycles from
//    first accept (no stall), Out=29, Ovf=0.
//  2 N=4,G=2,K=2,S: (-8,-8),(3,-2) -> Out=58; (-8,7),(-8,7) -> Out=-112.
//  3 N=4,G=0,K=2,U: (15,15),(15,15) -> 225 then clamp to 255, Ovf=1; after
//    handshake next dot product (1,1),(1,1) -> Out=2, Ovf=0.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> Out, out_valid,
//    Ovf stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE.
//  5 Rst high during MUL cycle 2 -> next edge all outputs reset values,
//    in_ready=1; following K terms yield sum excluding aborted term.
//  6 in_valid held high continuously, K=3, U, (2,2) each -> exactly 3
//    accepts, Out=12; pair present during DONE not consumed until IDLE.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the serial multiply-accumulate block: FSM state
// encoding, accumulator width, counter widths and saturation bounds.
package mac_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StAcc  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Accumulator width: full product plus guard bits.
  function automatic int unsigned acw_f(int unsigned n, int unsigned g);
    return 2 * n + g;
  endfunction

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Largest representable accumulator value.
  function automatic longint sat_max(int unsigned acw, bit is_signed);
    return is_signed ? (longint'(1) <<< (acw - 1)) - 1 : (longint'(1) <<< acw) - 1;
  endfunction

  // Smallest representable accumulator value.
  function automatic longint sat_min(int unsigned acw, bit is_signed);
    return is_signed ? -(longint'(1) <<< (acw - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// N-bit unsigned serial multiplier: one multiplier bit per cycle, 2N-bit product.
// start loads the operands; busy stays high for N cycles; done pulses for one
// cycle afterwards while product holds the final value.
module shift_add_mult
  import mac_pkg::*;
#(
  parameter int unsigned N = 18
) (
  input  logic           clk,
  input  logic           Rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = cnt_w(N - 1);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Next state: load on start, otherwise one shift-add step per busy cycle.
  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/mac_iter_acc.sv
// Serial multiply-accumulate: accepts one W/X pair at a time, multiplies the
// magnitudes bit-serially, applies the sign, adds into a saturating accumulator
// and presents the sum after K terms on a valid/ready output.
module mac_iter_acc
  import mac_pkg::*;
#(
  parameter int unsigned N      = 18,
  parameter int unsigned G      = 4,
  parameter int unsigned K      = 8,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned ACW   = acw_f(N, G)
) (
  input  logic           clk,
  input  logic           Rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   W,
  input  logic [N-1:0]   X,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [ACW-1:0] Out,
  output logic           Ovf
);

  // Two extra bits so the raw sum never wraps before it is clamped.
  localparam int unsigned SatW = ACW + 2;
  localparam int unsigned BW   = cnt_w(N - 1);
  localparam int unsigned TW   = cnt_w(K);
  localparam logic signed [SatW-1:0] SatMax = SatW'(sat_max(ACW, SIGNED));
  localparam logic signed [SatW-1:0] SatMin = SatW'(sat_min(ACW, SIGNED));

  state_e          state_q, state_d;
  logic [ACW-1:0]  ac_q, ac_d;
  logic [TW-1:0]   term_q, term_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            sign_q, sign_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic [N-1:0]    w_mag, x_mag;
  logic            mult_busy, mult_done;
  logic [2*N-1:0]  mult_product;

  logic signed [SatW-1:0] ac_ext, prod_ext, sum;
  logic [ACW-1:0]         sat_res;
  logic                   sat_hit;

  assign accept = in_valid && (state_q == StIdle);

  // Operand magnitudes; in signed mode the most negative value still fits in N bits.
  always_comb begin
    w_mag = W;
    x_mag = X;
    if (SIGNED && W[N-1]) begin
      w_mag = ~W + 1'b1;
    end
    if (SIGNED && X[N-1]) begin
      x_mag = ~X + 1'b1;
    end
  end

  shift_add_mult #(
    .N(N)
  ) u_mult (
    .clk    (clk),
    .Rst    (Rst),
    .start  (accept),
    .a      (w_mag),
    .b      (x_mag),
    .busy   (mult_busy),
    .done   (mult_done),
    .product(mult_product)
  );

  // Sign-apply the product, add to the accumulator and clamp to the legal range.
  always_comb begin
    if (SIGNED) begin
      ac_ext = SatW'(signed'(ac_q));
    end else begin
      ac_ext = SatW'(ac_q);
    end
    prod_ext = SatW'(mult_product);
    if (SIGNED && sign_q) begin
      prod_ext = -prod_ext;
    end
    sum     = ac_ext + prod_ext;
    sat_res = sum[ACW-1:0];
    sat_hit = 1'b0;
    if (sum > SatMax) begin
      sat_res = SatMax[ACW-1:0];
      sat_hit = 1'b1;
    end else if (sum < SatMin) begin
      sat_res = SatMin[ACW-1:0];
      sat_hit = 1'b1;
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    term_d    = term_q;
    bit_cnt_d = bit_cnt_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StMul;
          bit_cnt_d = '0;
          sign_d    = SIGNED ? (W[N-1] ^ X[N-1]) : 1'b0;
        end
      end
      StMul: begin
        if (mult_busy) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(N - 1)) begin
            bit_cnt_d = '0;
            state_d   = StAcc;
          end
        end
      end
      StAcc: begin
        if (mult_done) begin
          ac_d    = sat_res;
          ovf_d   = ovf_q | sat_hit;
          term_d  = term_q + 1'b1;
          state_d = (term_q == TW'(K - 1)) ? StDone : StIdle;
        end
      end
      StDone: begin
        if (out_ready) begin
          ac_d    = '0;
          term_d  = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any term in flight.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      ac_q      <= '0;
      term_q    <= '0;
      bit_cnt_q <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ac_q      <= ac_d;
      term_q    <= term_d;
      bit_cnt_q <= bit_cnt_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Out       = ac_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_mac_iter_acc.sv
// Bench for mac_iter_acc: four instances (unsigned, signed, no guard bits, K=3)
// driven with directed and random dot products, checked against an integer model.
module tb_mac_iter_acc;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [NDUT];
  logic       in_valid  [NDUT];
  logic [3:0] w         [NDUT];
  logic [3:0] x         [NDUT];
  logic       out_ready [NDUT];
  logic       in_ready  [NDUT];
  logic       out_valid [NDUT];
  logic       ovf       [NDUT];
  logic [9:0] out_w     [NDUT];
  logic [7:0] out_c;

  assign out_w[2] = {2'b00, out_c};

  int acw_c [NDUT] = '{10, 10, 8, 10};
  bit sgn_c [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int k_c   [NDUT] = '{2, 2, 2, 3};

  longint m_acc [NDUT];
  bit     m_ovf [NDUT];

  int n_assert = 0;
  int n_fail   = 0;

  mac_iter_acc #(.N(4), .G(2), .K(2), .SIGNED(1'b0)) u_a (
    .clk(clk), .Rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .W(w[0]),
    .X(x[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .Out(out_w[0]), .Ovf(ovf[0])
  );
  mac_iter_acc #(.N(4), .G(2), .K(2), .SIGNED(1'b1)) u_b (
    .clk(clk), .Rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .W(w[1]),
    .X(x[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .Out(out_w[1]), .Ovf(ovf[1])
  );
  mac_iter_acc #(.N(4), .G(0), .K(2), .SIGNED(1'b0)) u_c (
    .clk(clk), .Rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .W(w[2]),
    .X(x[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .Out(out_c), .Ovf(ovf[2])
  );
  mac_iter_acc #(.N(4), .G(2), .K(3), .SIGNED(1'b0)) u_d (
    .clk(clk), .Rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .W(w[3]),
    .X(x[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .Out(out_w[3]), .Ovf(ovf[3])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product added, then clamped to the accumulator range.
  function automatic void model_term(input int d, input int wv, input int xv);
    longint ws, xs, hi, lo;
    ws = wv;
    xs = xv;
    if (sgn_c[d]) begin
      if (wv > 7) ws = wv - 16;
      if (xv > 7) xs = xv - 16;
      hi = (longint'(1) << (acw_c[d] - 1)) - 1;
      lo = -(longint'(1) << (acw_c[d] - 1));
    end else begin
      hi = (longint'(1) << acw_c[d]) - 1;
      lo = 0;
    end
    m_acc[d] = m_acc[d] + ws * xs;
    if (m_acc[d] > hi) begin
      m_acc[d] = hi;
      m_ovf[d] = 1'b1;
    end else if (m_acc[d] < lo) begin
      m_acc[d] = lo;
      m_ovf[d] = 1'b1;
    end
  endfunction

  function automatic longint m_out(input int d);
    return m_acc[d] & ((longint'(1) << acw_c[d]) - 1);
  endfunction

  task automatic send(input int d, input int wv, input int xv);
    int n = 0;
    while (in_ready[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_ready_timeout", 64'(in_ready[d]), 64'd1);
    in_valid[d] = 1'b1;
    w[d] = wv[3:0];
    x[d] = xv[3:0];
    @(negedge clk);
    in_valid[d] = 1'b0;
    model_term(d, wv, xv);
  endtask

  task automatic finish_dot(input int d, input string tag, input longint exp_out,
                            input bit exp_ovf);
    int n = 0;
    while (out_valid[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(out_valid[d]), 64'd1);
    chk({tag, "_out"}, 64'(out_w[d]), 64'(exp_out));
    chk({tag, "_ovf"}, 64'(ovf[d]), 64'(exp_ovf));
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk({tag, "_post_ready"}, 64'(in_ready[d]), 64'd1);
    chk({tag, "_post_valid"}, 64'(out_valid[d]), 64'd0);
    chk({tag, "_post_out"}, 64'(out_w[d]), 64'd0);
    m_acc[d] = 0;
    m_ovf[d] = 1'b0;
  endtask

  initial begin
    int cyc, acc2, accepts;
    for (int i = 0; i < NDUT; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; w[i] = '0; x[i] = '0; out_ready[i] = 1'b0;
      m_acc[i] = 0; m_ovf[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;

    // Reset state of every instance.
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_in_ready", 64'(in_ready[i]), 64'd1);
      chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_out", 64'(out_w[i]), 64'd0);
      chk("rst_ovf", 64'(ovf[i]), 64'd0);
    end

    // 1: unsigned, back-to-back terms, latency check.
    in_valid[0] = 1'b1; w[0] = 4'd3; x[0] = 4'd5;
    @(negedge clk);
    cyc = 0; acc2 = -1;
    w[0] = 4'd7; x[0] = 4'd2;
    while (out_valid[0] !== 1'b1 && cyc < 200) begin
      if (in_ready[0] === 1'b1 && acc2 < 0) acc2 = cyc + 1;
      @(negedge clk);
      cyc++;
      if (acc2 >= 0) in_valid[0] = 1'b0;
    end
    in_valid[0] = 1'b0;
    chk("t1_accept_gap", 64'(acc2), 64'd6);
    chk("t1_done_latency", 64'(cyc + 1), 64'd12);
    finish_dot(0, "t1", 29, 1'b0);

    // 2: signed products.
    send(1, 8, 8); send(1, 3, 14);
    finish_dot(1, "t2a", 58, 1'b0);
    send(1, 8, 7); send(1, 8, 7);
    finish_dot(1, "t2b", 1024 - 112, 1'b0);

    // 3: unsigned saturation with no guard bits, then clean dot product.
    send(2, 15, 15); send(2, 15, 15);
    finish_dot(2, "t3a", 255, 1'b1);
    send(2, 1, 1); send(2, 1, 1);
    finish_dot(2, "t3b", 2, 1'b0);

    // 4: output backpressure with stray input pulses.
    send(0, 9, 9); send(0, 3, 4);
    cyc = 0;
    while (out_valid[0] !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = i[0]; w[0] = 4'd15; x[0] = 4'd15;
      @(negedge clk);
      chk("t4_hold_valid", 64'(out_valid[0]), 64'd1);
      chk("t4_hold_out", 64'(out_w[0]), 64'd93);
      chk("t4_hold_ovf", 64'(ovf[0]), 64'd0);
      chk("t4_hold_ready", 64'(in_ready[0]), 64'd0);
    end
    in_valid[0] = 1'b0;
    finish_dot(0, "t4", 93, 1'b0);
    send(0, 1, 2); send(0, 2, 2);
    finish_dot(0, "t4n", 6, 1'b0);

    // 5: reset during MUL cycle 2 of the second term.
    send(0, 5, 5);
    in_valid[0] = 1'b1; w[0] = 4'd7; x[0] = 4'd7;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("t5_ready", 64'(in_ready[0]), 64'd1);
    chk("t5_valid", 64'(out_valid[0]), 64'd0);
    chk("t5_out", 64'(out_w[0]), 64'd0);
    chk("t5_ovf", 64'(ovf[0]), 64'd0);
    m_acc[0] = 0; m_ovf[0] = 1'b0;
    send(0, 2, 3); send(0, 4, 1);
    finish_dot(0, "t5", 10, 1'b0);

    // 6: in_valid held high, K=3.
    in_valid[3] = 1'b1; w[3] = 4'd2; x[3] = 4'd2;
    accepts = 0; cyc = 0;
    while (out_valid[3] !== 1'b1 && cyc < 200) begin
      if (in_ready[3] === 1'b1) accepts++;
      @(negedge clk);
      cyc++;
    end
    chk("t6_accepts", 64'(accepts), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t6_done_ready", 64'(in_ready[3]), 64'd0);
      @(negedge clk);
    end
    chk("t6_out", 64'(out_w[3]), 64'd12);
    chk("t6_ovf", 64'(ovf[3]), 64'd0);
    out_ready[3] = 1'b1;
    @(negedge clk);
    out_ready[3] = 1'b0;
    chk("t6_idle_ready", 64'(in_ready[3]), 64'd1);
    @(negedge clk);
    chk("t6_consumed", 64'(in_ready[3]), 64'd0);
    in_valid[3] = 1'b0;
    rst[3] = 1'b1;
    @(negedge clk);
    rst[3] = 1'b0;
    m_acc[3] = 0; m_ovf[3] = 1'b0;

    // Random dot products on every instance against the model.
    for (int rep = 0; rep < 4; rep++) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int t = 0; t < k_c[d]; t++) begin
          send(d, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        finish_dot(d, "rand", m_out(d), m_ovf[d]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
